// File: rtl/seq_mult_sa.sv
// Sequential shift-and-add multiplier: N-bit operands, 2N-bit product after N RUN cycles.
// Optional two's-complement operands when SIGNED_MULT_EN is defined (magnitude + sign out).
module seq_mult_sa #(
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           sign,
  output logic           busy,
  output logic           done,
  output logic           prod_valid,
  output logic           in_range
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2*N+13:0] DEC_LIMIT = 9999;

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d;
  logic           pv_q, pv_d;

  logic [N-1:0]   a_mag, b_mag;
  logic           sgn_in;

`ifdef SIGNED_MULT_EN
  // -2^(N-1) negates to itself, which reads correctly as 2^(N-1) unsigned
  always_comb begin
    a_mag  = a[N-1] ? N'(-a) : a;
    b_mag  = b[N-1] ? N'(-b) : b;
    sgn_in = a[N-1] ^ b[N-1];
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    sgn_in = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    pv_d     = pv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          pv_d     = 1'b0;
          sgn_d    = sgn_in;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          pv_d    = 1'b1;
          // a zero product is never reported as negative
          sgn_d   = sgn_q & (acc_d != '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      pv_q     <= pv_d;
    end
  end

  assign product    = acc_q;
  assign sign       = sgn_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign prod_valid = pv_q;
  assign in_range   = pv_q && ({14'd0, acc_q} <= DEC_LIMIT);

endmodule

// File: tb/tb_seq_mult_sa.sv
// Randomized and directed checks of seq_mult_sa against an arithmetic reference model.
module tb_seq_mult_sa;
  localparam int N = 7;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic [N-1:0]   a, b;
  logic [2*N-1:0] product;
  logic           sign, busy, done, prod_valid, in_range;

  int checks = 0;
  int errors = 0;

  seq_mult_sa #(.N(N)) dut (
    .clk(clk), .clr(clr), .start(start), .a(a), .b(b),
    .product(product), .sign(sign), .busy(busy), .done(done),
    .prod_valid(prod_valid), .in_range(in_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply, operands interpreted per build mode
  task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv,
                       output int mag, output bit neg);
    int sa, sb, p;
    sa = int'(av);
    sb = int'(bv);
`ifdef SIGNED_MULT_EN
    if (av[N-1]) sa = sa - (1 << N);
    if (bv[N-1]) sb = sb - (1 << N);
`endif
    p   = sa * sb;
    neg = (p < 0);
    mag = neg ? -p : p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a multiply and follow it cycle by cycle; returns one cycle after the done pulse.
  task automatic run_mult(input logic [N-1:0] av, input logic [N-1:0] bv, input bit hold);
    int  mag;
    bit  neg;
    model(av, bv, mag, neg);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    for (int i = 0; i < N; i++) begin
      if (i > 0) tick();
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("pv_run", prod_valid, 0);
    end
    tick();
    check("busy_end", busy, 0);
    check("done_pulse", done, 1);
    check("product", product, mag);
    check("sign", sign, neg);
    check("prod_valid", prod_valid, 1);
    check("in_range", in_range, (mag <= 9999));
    tick();
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
    check("product_hold", product, mag);
    check("pv_hold", prod_valid, 1);
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b1;
    a = 7'd12;
    b = 7'd11;
    tick();
    tick();
    check("rst_product", product, 0);
    check("rst_sign", sign, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pv", prod_valid, 0);
    check("rst_in_range", in_range, 0);
    clr = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    run_mult(7'd12, 7'd11, 1'b0);
    run_mult(7'd127, 7'd127, 1'b0);
    run_mult(7'd0, 7'd93, 1'b0);

    // continuous start: second accept lands exactly on k+N+2
    run_mult(7'd45, 7'd99, 1'b1);
    run_mult(7'd100, 7'd101, 1'b1);
    start = 1'b0;
    tick();
    tick();

    // reset during the 4th RUN cycle, with a start on the same edge
    a = 7'd90;
    b = 7'd90;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy, 1);
    clr = 1'b1;
    start = 1'b1;
    tick();
    check("mid_rst_product", product, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pv", prod_valid, 0);
    check("mid_rst_sign", sign, 0);
    clr = 1'b0;
    start = 1'b0;
    tick();
    check("mid_rst_ignored", busy, 0);
    run_mult(7'd3, 7'd5, 1'b0);

`ifdef SIGNED_MULT_EN
    run_mult(7'h7B, 7'd7, 1'b0);
    run_mult(7'h40, 7'h40, 1'b0);
    run_mult(7'h7D, 7'd0, 1'b0);
`endif

    for (int t = 0; t < 25; t++) begin
      run_mult(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
      start = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
